// File: rtl/button_event_decoder.sv
// ----------------------------------------------------------------------------
// button_event_decoder
//
// Turns the clean, debounced level of one push-button into gesture events for
// the menu and mode-control FSMs. A press is classified once it is complete:
// a short press (released, then no second press within the gap window), a
// long press (held for LONG_CYCLES), or a double click (second press started
// inside the gap window). Raw edge pulses are also provided.
//
// Parameters:
//   LONG_CYCLES  cycles after the rise pulse until long_press fires (>= 2)
//   GAP_CYCLES   cycles after the fall pulse within which a new press counts
//                as a double click; otherwise short_press fires (>= 2)
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   btn           in   debounced button level, 1 = pressed, synchronous to clk
//   rise          out  one-cycle pulse on the 0->1 edge of btn
//   fall          out  one-cycle pulse on the 1->0 edge of btn
//   short_press   out  one-cycle pulse, single short press confirmed
//   long_press    out  one-cycle pulse, press held for LONG_CYCLES
//   double_click  out  one-cycle pulse, second press inside the gap window
//   held          out  level, high while a long press is still being held
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 30_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise,
  output logic fall,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;

  logic rise_q, fall_q, short_q, long_q, dbl_q, held_q;
  logic rise_d, fall_d, short_d, long_d, dbl_d, held_d;

  logic re, fe;

  always_comb begin
    re = btn & ~btn_q;
    fe = ~btn & btn_q;

    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (re) state_d = PRESS1;
      end
      PRESS1: begin
        // Release beats the long threshold when both land on the same cycle.
        if (fe) begin
          state_d = GAP;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fe) state_d = IDLE;
      end
      GAP: begin
        // A new press beats the gap timeout when both land on the same cycle.
        if (re) begin
          dbl_d   = 1'b1;
          state_d = RELEASE;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      RELEASE: begin
        // Second press of a double click never turns into a long press.
        if (fe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state change; saturates rather than wraps.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == PRESS1 || state_q == GAP) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    rise_d = re;
    fall_d = fe;
    held_d = (state_d == LONG_HELD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
    end
  end

  assign rise         = rise_q;
  assign fall         = fall_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// ----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Directed bench for button_event_decoder with LONG_CYCLES=8, GAP_CYCLES=6.
// Inputs are driven 1 time unit after each rising edge; a negedge monitor
// counts pulses of every output and records the cycle index of the most
// recent pulse, so each scenario checks counts and relative timing.
// ----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int LONG_C = 8;
  localparam int GAP_C  = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn = 1'b0;
  logic rise, fall, short_press, long_press, double_click, held;

  button_event_decoder #(
    .LONG_CYCLES(LONG_C),
    .GAP_CYCLES (GAP_C)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .rise        (rise),
    .fall        (fall),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .held        (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_rise, n_fall, n_short, n_long, n_dbl, n_held, n_excl;
  int c_rise, c_fall, c_short, c_long, c_dbl, c_held_first;

  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    if (rise)         begin n_rise++;  c_rise  = cyc; end
    if (fall)         begin n_fall++;  c_fall  = cyc; end
    if (short_press)  begin n_short++; c_short = cyc; end
    if (long_press)   begin n_long++;  c_long  = cyc; end
    if (double_click) begin n_dbl++;   c_dbl   = cyc; end
    if (held) begin
      if (n_held == 0) c_held_first = cyc;
      n_held++;
    end
    if ((32'(short_press) + 32'(long_press) + 32'(double_click)) > 1) n_excl++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    n_rise = 0; n_fall = 0; n_short = 0; n_long = 0; n_dbl = 0; n_held = 0;
    c_rise = -1; c_fall = -1; c_short = -1; c_long = -1; c_dbl = -1; c_held_first = -1;
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    tick(hi);
    btn = 1'b0;
    tick(lo);
  endtask

  function automatic int outs();
    return {26'd0, rise, fall, short_press, long_press, double_click, held};
  endfunction

  initial begin
    n_excl = 0;
    clear_mon();

    // Reset and idle
    tick(3);
    check("outputs_in_reset", outs(), 0);
    reset_n = 1'b1;
    tick(20);
    check("idle_no_events", n_rise + n_fall + n_short + n_long + n_dbl + n_held, 0);

    // Short press: 3 high, 20 low
    clear_mon();
    press(3, 20);
    check("short_rise_cnt", n_rise, 1);
    check("short_fall_cnt", n_fall, 1);
    check("short_fall_delay", c_fall - c_rise, 3);
    check("short_cnt", n_short, 1);
    check("short_delay", c_short - c_fall, GAP_C);
    check("short_no_long", n_long, 0);
    check("short_no_dbl", n_dbl, 0);

    // Long press: 20 high, 10 low
    clear_mon();
    press(20, 10);
    check("long_cnt", n_long, 1);
    check("long_delay", c_long - c_rise, LONG_C);
    check("held_first", c_held_first, c_long);
    check("held_len", n_held, 20 - LONG_C);
    check("long_fall_delay", c_fall - c_rise, 20);
    check("long_no_short", n_short, 0);
    check("long_no_dbl", n_dbl, 0);
    check("held_low_after", 32'(held), 0);

    // Double click: 3 high, 4 low, 10 high, 10 low
    clear_mon();
    press(3, 4);
    press(10, 10);
    check("dbl_rise_cnt", n_rise, 2);
    check("dbl_cnt", n_dbl, 1);
    check("dbl_at_rise", c_dbl, c_rise);
    check("dbl_no_short", n_short, 0);
    check("dbl_no_long", n_long, 0);
    check("dbl_fall_cnt", n_fall, 2);

    // Gap of exactly GAP_C cycles: second rise meets timeout, rise wins
    clear_mon();
    press(3, GAP_C);
    press(3, 10);
    check("edge_gap_dbl", n_dbl, 1);
    check("edge_gap_no_short", n_short, 0);

    // Gap of GAP_C+1 cycles: timeout first, then a fresh short press
    clear_mon();
    press(3, GAP_C + 1);
    press(3, 10);
    check("late_gap_short", n_short, 2);
    check("late_gap_no_dbl", n_dbl, 0);

    // Reset mid-press aborts the gesture
    clear_mon();
    btn = 1'b1;
    tick(5);
    clear_mon();
    reset_n = 1'b0;
    #1;
    check("outputs_mid_reset", outs(), 0);
    btn = 1'b0;
    tick(2);
    check("outputs_held_reset", outs(), 0);
    reset_n = 1'b1;
    tick(20);
    check("abort_no_events", n_rise + n_fall + n_short + n_long + n_dbl + n_held, 0);

    // Normal operation after the aborted gesture
    press(3, 10);
    check("post_reset_short", n_short, 1);
    check("post_reset_delay", c_short - c_fall, GAP_C);

    check("pulse_exclusive", n_excl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Downstream stage of the early-sampling debouncer. Consumes the clean debounced level and classifies user activity on one push-button.
- Emits single-cycle event pulses: rise, fall, short_press, long_press and double_click. Also emits a "held" level.
- Feeds menu and mode-control FSMs that need gesture-level events rather than raw edges.

Parameters:
- LONG_CYCLES, default 50_000_000: cycles the button must stay high after the rise pulse before long_press fires. Minimum 2.
- GAP_CYCLES, default 30_000_000: maximum cycles after a release within which a second press counts as a double click. Minimum 2.
- CNT_W, default $clog2(max(LONG_CYCLES,GAP_CYCLES)+1): shared counter width. Derived; do not override.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- btn  input  1  debounced button level (1 = pressed). Already synchronous to clk.
- rise  output  1  one-cycle pulse on the 0→1 edge of btn.
- fall  output  1  one-cycle pulse on the 1→0 edge of btn.
- short_press  output  1  one-cycle pulse: single short press confirmed.
- long_press  output  1  one-cycle pulse: press held for LONG_CYCLES.
- double_click  output  1  one-cycle pulse: second press started within the gap window.
- held  output  1  level; high while in LONG_HELD.

Behaviour:
- All outputs are registered. Reset drives every output to 0, the state to IDLE, the counter to 0 and btn_q to 0.
- btn_q is btn delayed by one clock.
  - Rise edge (re) = btn & ~btn_q. Fall edge (fe) = ~btn & btn_q.
- rise and fall are asserted in the cycle after the clock edge at which re or fe is sampled. They are independent of FSM state.
- Counter rules:
  - Cleared on every state change.
  - Increments by 1 per cycle in PRESS1 and GAP.
  - Holds in all other states and never wraps.
- States and transitions:
  - IDLE: on re → PRESS1.
  - PRESS1:
    - fe → GAP.
    - Else if count == LONG_CYCLES-1 → assert long_press and go to LONG_HELD.
    - long_press is therefore high exactly LONG_CYCLES cycles after rise.
  - LONG_HELD: held=1. fe → IDLE. No short_press or double_click is produced from this press.
  - GAP:
    - re → assert double_click and go to RELEASE.
    - Else if count == GAP_CYCLES-1 → assert short_press and go to IDLE.
    - short_press is therefore high exactly GAP_CYCLES cycles after fall.
  - RELEASE: fe → IDLE. The second press generates no long_press, however long it is held.
- Priority: in GAP, re wins over timeout in the same cycle. In PRESS1, fe wins over the long threshold in the same cycle.
- Event pulses are mutually exclusive. At most one of short_press, long_press and double_click is high in any cycle.
- A button already high when reset releases is seen as a rise on the first clock and starts a press. This is intended.
- Reset asserted mid-operation aborts any pending event. No pulse is emitted for the aborted gesture.
- The design is a single always block for state plus counter and registered outputs. No combinational outputs.

Test Plan (LONG_CYCLES=8, GAP_CYCLES=6 unless stated):
- Reset, then btn=0 for 20 cycles → all outputs remain 0 and the state stays IDLE.
- btn high for 3 cycles, then low for 20 cycles → rise once, fall once, then short_press exactly 6 cycles after fall. No long_press, no double_click.
- btn high for 20 cycles → long_press 8 cycles after rise. held=1 from the cycle long_press rises until the cycle after fall. No short_press follows the release.
- Press 3 cycles, release 4 cycles, press 10 cycles → double_click in the cycle of the second rise. No short_press or long_press.
- Release gap of exactly 6 cycles between presses (second re sampled at count==5) → double_click, not short_press (priority check).
- Press held 5 cycles, reset_n pulsed low, then btn released → no pulses after reset. Outputs 0 during reset. The next press behaves normally.
